// File: rtl/shl_64b_core_if.sv
// shl_64b_core_if: operand/result bundle for shl_64b_core.
// master drives carry_i, shift_i, in_data_i, in_valid_i and receives out_data_o, out_valid_o.
// slave is the shifter side.
// SHL_64B_CORE_OVF_EN adds out_ovf_o, which is set when a 1 is shifted out past bit 63.
interface shl_64b_core_if;
  logic        carry_i;
  logic [5:0]  shift_i;
  logic [63:0] in_data_i;
  logic        in_valid_i;
  logic [63:0] out_data_o;
  logic        out_valid_o;
`ifdef SHL_64B_CORE_OVF_EN
  logic        out_ovf_o;
  modport master (output carry_i, shift_i, in_data_i, in_valid_i, input out_data_o, out_valid_o, out_ovf_o);
  modport slave  (input carry_i, shift_i, in_data_i, in_valid_i, output out_data_o, out_valid_o, out_ovf_o);
`else
  modport master (output carry_i, shift_i, in_data_i, in_valid_i, input out_data_o, out_valid_o);
  modport slave  (input carry_i, shift_i, in_data_i, in_valid_i, output out_data_o, out_valid_o);
`endif
endinterface

// File: rtl/shl_64b_core.sv
// shl_64b_core: 64-bit logical left barrel shifter that fills the vacated LSBs with carry_i.
// Ports: clk_i and rst_i (asynchronous, active-high), plus bus (shl_64b_core_if.slave).
// The bus carries the operand, shift, carry and valid inputs, and the result and valid outputs.
// OUT_REG=1 registers the outputs (latency 1). OUT_REG=0 drives them combinationally, and rst_i is ignored.
// SHL_64B_CORE_OVF_EN adds out_ovf_o, which reports any 1 bit shifted out past bit 63.
module shl_64b_core #(
  parameter bit OUT_REG = 1'b1
) (
  input logic clk_i,
  input logic rst_i,
  shl_64b_core_if.slave bus
);
  logic [63:0] data_d;
  // Six stages. Stage k shifts by 2^k and fills the 2^k vacated bits with carry_i.
  always_comb begin
    data_d = bus.in_data_i;
    for (int k = 0; k < 6; k++)
      data_d = bus.shift_i[k] ? ((data_d << (1 << k)) | ({64{bus.carry_i}} & ((64'd1 << (1 << k)) - 64'd1))) : data_d;
  end
`ifdef SHL_64B_CORE_OVF_EN
  logic        ovf_d;
  logic [63:0] acc;
  // Collect the top 2^k bits that each active stage pushes out of the word.
  always_comb begin
    acc   = bus.in_data_i;
    ovf_d = 1'b0;
    for (int k = 0; k < 6; k++) begin
      ovf_d = ovf_d | (bus.shift_i[k] & (|(acc >> (64 - (1 << k)))));
      acc   = bus.shift_i[k] ? acc << (1 << k) : acc;
    end
  end
`endif
  generate
    if (OUT_REG) begin : g_reg
      logic [63:0] data_q;
      logic        valid_q;
      always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
          data_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          data_q  <= data_d;
          valid_q <= bus.in_valid_i;
        end
      assign bus.out_data_o  = data_q;
      assign bus.out_valid_o = valid_q;
`ifdef SHL_64B_CORE_OVF_EN
      logic ovf_q;
      always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) ovf_q <= 1'b0;
        else       ovf_q <= ovf_d;
      assign bus.out_ovf_o = ovf_q;
`endif
    end else begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst  = clk_i ^ rst_i;
      assign bus.out_data_o  = data_d;
      assign bus.out_valid_o = bus.in_valid_i;
`ifdef SHL_64B_CORE_OVF_EN
      assign bus.out_ovf_o   = ovf_d;
`endif
    end
  endgenerate
endmodule

// File: tb/tb_shl_64b_core.sv
// tb_shl_64b_core: randomized and directed checks of shl_64b_core against an arithmetic reference.
// Both OUT_REG builds are instantiated.
module tb_shl_64b_core;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic chk = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;

  shl_64b_core_if bus ();
  shl_64b_core_if cb ();
  shl_64b_core #(.OUT_REG(1'b1)) dut  (.clk_i(clk), .rst_i(rst), .bus(bus));
  shl_64b_core #(.OUT_REG(1'b0)) dutc (.clk_i(clk), .rst_i(rst), .bus(cb));
  assign cb.carry_i    = bus.carry_i;
  assign cb.shift_i    = bus.shift_i;
  assign cb.in_data_i  = bus.in_data_i;
  assign cb.in_valid_i = bus.in_valid_i;

  function automatic logic [63:0] ref_shl(logic [63:0] d, int s, logic c);
    return (d << s) | (c ? ((64'd1 << s) - 64'd1) : 64'd0);
  endfunction
  function automatic logic ref_ovf(logic [63:0] d, int s);
    return (s == 0) ? 1'b0 : |(d >> (64 - s));
  endfunction

  task automatic cmp(string n, logic [63:0] a, logic [63:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  // Reference for the registered build: what the outputs must hold after the last edge.
  logic [63:0] m_data = '0;
  logic        m_valid = 1'b0;
  logic        m_ovf = 1'b0;
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_data = '0;
      m_valid = 1'b0;
      m_ovf = 1'b0;
    end else begin
      m_data = ref_shl(bus.in_data_i, int'(bus.shift_i), bus.carry_i);
      m_valid = bus.in_valid_i;
      m_ovf = ref_ovf(bus.in_data_i, int'(bus.shift_i));
    end

  always @(negedge clk)
    if (chk) begin
      cmp("reg_data", bus.out_data_o, m_data);
      cmp("reg_valid", {63'd0, bus.out_valid_o}, {63'd0, m_valid});
      cmp("comb_data", cb.out_data_o, ref_shl(bus.in_data_i, int'(bus.shift_i), bus.carry_i));
      cmp("comb_valid", {63'd0, cb.out_valid_o}, {63'd0, bus.in_valid_i});
`ifdef SHL_64B_CORE_OVF_EN
      cmp("reg_ovf", {63'd0, bus.out_ovf_o}, {63'd0, m_ovf});
      cmp("comb_ovf", {63'd0, cb.out_ovf_o}, {63'd0, ref_ovf(bus.in_data_i, int'(bus.shift_i))});
`endif
    end

  task automatic drive(logic [63:0] d, int s, logic c, logic v);
    @(posedge clk);
    #1;
    bus.in_data_i = d;
    bus.shift_i = 6'(s);
    bus.carry_i = c;
    bus.in_valid_i = v;
  endtask

  task automatic lit(string n, logic [63:0] d, int s, logic c, logic [63:0] e, logic eo);
    drive(d, s, c, 1'b1);
    @(posedge clk);
    @(negedge clk);
    cmp(n, bus.out_data_o, e);
    cmp({n, "_v"}, {63'd0, bus.out_valid_o}, 64'd1);
`ifdef SHL_64B_CORE_OVF_EN
    cmp({n, "_ovf"}, {63'd0, bus.out_ovf_o}, {63'd0, eo});
`else
    if (eo === 1'bx) $display("unexpected ovf literal");
`endif
  endtask

  initial begin
    bus.in_data_i = '0;
    bus.shift_i = '0;
    bus.carry_i = 1'b0;
    bus.in_valid_i = 1'b0;
    #1 rst = 1'b1;
    #1;
    cmp("rst_data", bus.out_data_o, 64'd0);
    cmp("rst_valid", {63'd0, bus.out_valid_o}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    chk = 1'b1;
    lit("p4c0", 64'h0123_4567_89ab_cdef, 4, 1'b0, 64'h1234_5678_9abc_def0, 1'b0);
    lit("p4c1", 64'h0123_4567_89ab_cdef, 4, 1'b1, 64'h1234_5678_9abc_deff, 1'b0);
    lit("p0c1", 64'h0123_4567_89ab_cdef, 0, 1'b1, 64'h0123_4567_89ab_cdef, 1'b0);
    lit("p63c0", 64'hffff_ffff_ffff_ffff, 63, 1'b0, 64'h8000_0000_0000_0000, 1'b1);
    lit("p63c1", 64'hffff_ffff_ffff_ffff, 63, 1'b1, 64'hffff_ffff_ffff_ffff, 1'b1);
    lit("msb_out", 64'h8000_0000_0000_0000, 1, 1'b0, 64'd0, 1'b1);
    lit("to_msb", 64'h4000_0000_0000_0000, 1, 1'b0, 64'h8000_0000_0000_0000, 1'b0);
    for (int c = 0; c < 2; c++)
      for (int s = 0; s < 64; s++) begin
        drive(64'hfedc_ba98_7654_3210, s, c[0], 1'b1);
        if (c == 1 && s == 20) begin
          @(posedge clk);
          #2 rst = 1'b1;
          #1;
          cmp("async_rst_data", bus.out_data_o, 64'd0);
          cmp("async_rst_valid", {63'd0, bus.out_valid_o}, 64'd0);
          @(negedge clk);
          #1 rst = 1'b0;
        end
      end
    for (int i = 0; i < 400; i++)
      drive({$urandom, $urandom}, int'($urandom_range(0, 63)), 1'($urandom), 1'($urandom));
    drive(64'd0, 0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
